// File: rtl/instr_sequencer.sv
// i281 multicycle front end: fetch handshake, IR, one-hot decode,
// flag sampling and FETCH/DECODE/EXEC/MEM phase strobes.
module instr_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic             fetch_ack,
  input  logic [15:0]      instr_in,
  input  logic             mem_ack,
  input  logic [3:0]       flag_in,
  output logic             fetch_req,
  output logic [26:0]      op_out,
  output logic [3:0]       flag_out,
  output logic [3:0]       phase,
  output logic             exec_en,
  output logic             mem_en,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] PH_FETCH  = 4'b0001;
  localparam logic [3:0] PH_DECODE = 4'b0010;
  localparam logic [3:0] PH_EXEC   = 4'b0100;
  localparam logic [3:0] PH_MEM    = 4'b1000;

  logic [15:0] ir;
  logic [22:0] oh;
  logic        is_mem;
  logic        retire;
  logic        unused_ir;

  // Low byte carries immediates/addresses for the datapath, not decode.
  assign unused_ir = ^ir[7:0];

  always_comb begin
    oh = '0;
    unique case (ir[15:12])
      4'h0: oh[0]  = 1'b1;
      4'h1: oh[4:1] = 4'b0001 << ir[9:8];
      4'h2: oh[5]  = 1'b1;
      4'h3: oh[6]  = 1'b1;
      4'h4: oh[7]  = 1'b1;
      4'h5: oh[8]  = 1'b1;
      4'h6: oh[9]  = 1'b1;
      4'h7: oh[10] = 1'b1;
      4'h8: oh[11] = 1'b1;
      4'h9: oh[12] = 1'b1;
      4'hA: oh[13] = 1'b1;
      4'hB: oh[14] = 1'b1;
      4'hC: oh[16:15] = ir[8] ? 2'b10 : 2'b01;
      4'hD: oh[17] = 1'b1;
      4'hE: oh[18] = 1'b1;
      4'hF: oh[22:19] = 4'b0001 << ir[9:8];
      default: oh[0] = 1'b1;
    endcase
  end

  // IR only changes on entry to DECODE, so op_out holds until the next one.
  assign op_out    = {ir[11:8], oh};
  assign is_mem    = |{oh[14:11], oh[4:1]};
  assign fetch_req = phase[0] & ~halt & ~reset;
  assign exec_en   = phase[2];
  assign mem_en    = phase[3];
  assign retire    = (phase[2] & ~is_mem)
                   | (phase[3] & mem_ack);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase    <= PH_FETCH;
      ir       <= '0;
      flag_out <= '0;
    end else begin
      unique case (1'b1)
        phase[0]: begin
          if (fetch_req && fetch_ack) begin
            ir       <= instr_in;
            flag_out <= flag_in;
            phase    <= PH_DECODE;
          end
        end
        phase[1]: phase <= PH_EXEC;
        phase[2]: phase <= is_mem ? PH_MEM : PH_FETCH;
        phase[3]: if (mem_ack) phase <= PH_FETCH;
        default:  phase <= PH_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      instr_count <= '0;
    else if (retire && instr_count != '1)
      instr_count <= instr_count + 1'b1;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: vector table plus
// halt, async-reset and decode-sweep sequences.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt;
  logic        fetch_ack;
  logic [15:0] instr_in;
  logic        mem_ack;
  logic [3:0]  flag_in;
  logic        fetch_req;
  logic [26:0] op_out;
  logic [3:0]  flag_out;
  logic [3:0]  phase;
  logic        exec_en;
  logic        mem_en;
  logic [15:0] instr_count;

  logic        s_fetch_req;
  logic [26:0] s_op_out;
  logic [3:0]  s_flag_out;
  logic [3:0]  s_phase;
  logic        s_exec_en;
  logic        s_mem_en;
  logic [1:0]  s_count;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .fetch_ack(fetch_ack), .instr_in(instr_in),
    .mem_ack(mem_ack), .flag_in(flag_in),
    .fetch_req(fetch_req), .op_out(op_out),
    .flag_out(flag_out), .phase(phase),
    .exec_en(exec_en), .mem_en(mem_en),
    .instr_count(instr_count)
  );

  instr_sequencer #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .halt(halt),
    .fetch_ack(fetch_ack), .instr_in(instr_in),
    .mem_ack(mem_ack), .flag_in(flag_in),
    .fetch_req(s_fetch_req), .op_out(s_op_out),
    .flag_out(s_flag_out), .phase(s_phase),
    .exec_en(s_exec_en), .mem_en(s_mem_en),
    .instr_count(s_count)
  );

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  flags;
    int          waitn;
    logic [26:0] exp_op;
    logic        exp_mem;
  } vec_t;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [26:0] ref_op(input logic [15:0] w);
    int b;
    logic [22:0] v;
    case (w[15:12])
      4'h0: b = 0;
      4'h1: b = 1 + int'(w[9:8]);
      4'hC: b = 15 + int'(w[8]);
      4'hD: b = 17;
      4'hE: b = 18;
      4'hF: b = 19 + int'(w[9:8]);
      default: b = int'(w[15:12]) + 3;
    endcase
    v = '0;
    v[b] = 1'b1;
    return {w[11:8], v};
  endfunction

  function automatic logic ref_mem(input logic [15:0] w);
    return (w[15:12] == 4'h1) || (w[15:12] >= 4'h8 && w[15:12] <= 4'hB);
  endfunction

  function automatic int sat3(input int c);
    return (c > 3) ? 3 : c;
  endfunction

  task automatic run_instr(input vec_t v);
    chk("fetch_phase", 32'(phase), 32'h1);
    chk("fetch_req", 32'(fetch_req), 32'h1);
    instr_in  = v.instr;
    flag_in   = v.flags;
    fetch_ack = 1'b1;
    @(negedge clk);
    fetch_ack = 1'b0;
    flag_in   = ~v.flags;
    instr_in  = 16'h0000;
    chk("dec_phase", 32'(phase), 32'h2);
    chk("dec_op", 32'(op_out), 32'(v.exp_op));
    chk("dec_flag", 32'(flag_out), 32'(v.flags));
    chk("dec_exec_en", 32'(exec_en), 32'h0);
    chk("dec_fetch_req", 32'(fetch_req), 32'h0);
    @(negedge clk);
    chk("exe_phase", 32'(phase), 32'h4);
    chk("exe_exec_en", 32'(exec_en), 32'h1);
    chk("exe_op", 32'(op_out), 32'(v.exp_op));
    chk("exe_flag", 32'(flag_out), 32'(v.flags));
    chk("exe_mem_en", 32'(mem_en), 32'h0);
    if (v.exp_mem) begin
      for (int i = 0; i < v.waitn; i++) begin
        @(negedge clk);
        chk("mem_phase", 32'(phase), 32'h8);
        chk("mem_en", 32'(mem_en), 32'h1);
        chk("mem_exec_en", 32'(exec_en), 32'h0);
        chk("mem_count", 32'(instr_count), 32'(exp_cnt));
        if (i == v.waitn - 1) mem_ack = 1'b1;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    exp_cnt++;
    chk("ret_phase", 32'(phase), 32'h1);
    chk("ret_count", 32'(instr_count), 32'(exp_cnt));
    chk("ret_sat_count", 32'(s_count), 32'(sat3(exp_cnt)));
    chk("ret_op_hold", 32'(op_out), 32'(v.exp_op));
  endtask

  vec_t vt[13];
  vec_t sv;
  logic [26:0] held_op;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{16'h4600, 4'b0000, 0, 27'h3000080, 1'b0};
    vt[1]  = '{16'hF300, 4'b0010, 0, 27'h1C00000, 1'b0};
    vt[2]  = '{16'h8105, 4'b1001, 3, 27'h0800800, 1'b1};
    vt[3]  = '{16'h0000, 4'b0100, 0, 27'h0000001, 1'b0};
    vt[4]  = '{16'h1200, 4'b0000, 1, 27'h1000008, 1'b1};
    vt[5]  = '{16'h1300, 4'b1111, 2, 27'h1800010, 1'b1};
    vt[6]  = '{16'hB0FF, 4'b0001, 1, 27'h0004000, 1'b1};
    vt[7]  = '{16'hC100, 4'b0000, 0, 27'h0810000, 1'b0};
    vt[8]  = '{16'hD000, 4'b1000, 0, 27'h0020000, 1'b0};
    vt[9]  = '{16'hA700, 4'b0000, 1, 27'h3802000, 1'b1};
    vt[10] = '{16'h2500, 4'b0000, 0, 27'h2800020, 1'b0};
    vt[11] = '{16'hE9AB, 4'b0110, 0, 27'h4840000, 1'b0};
    vt[12] = '{16'h9F00, 4'b0011, 2, 27'h7801000, 1'b1};

    reset = 1'b1; halt = 1'b0; fetch_ack = 1'b0;
    instr_in = 16'h0; mem_ack = 1'b0; flag_in = 4'h0;
    @(negedge clk);
    chk("rst_phase", 32'(phase), 32'h1);
    chk("rst_op", 32'(op_out), 32'h1);
    chk("rst_flag", 32'(flag_out), 32'h0);
    chk("rst_fetch_req", 32'(fetch_req), 32'h0);
    chk("rst_exec_en", 32'(exec_en), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_count", 32'(instr_count), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_phase", 32'(phase), 32'h1);
    chk("idle_fetch_req", 32'(fetch_req), 32'h1);

    for (int i = 0; i < 13; i++) run_instr(vt[i]);

    held_op = op_out;
    halt = 1'b1;
    fetch_ack = 1'b1;
    instr_in = 16'h5A00;
    #1;
    chk("halt_fetch_req", 32'(fetch_req), 32'h0);
    @(negedge clk);
    chk("halt_phase", 32'(phase), 32'h1);
    @(negedge clk);
    chk("halt_phase2", 32'(phase), 32'h1);
    chk("halt_op", 32'(op_out), 32'(held_op));
    fetch_ack = 1'b0;
    halt = 1'b0;
    #1;
    chk("unhalt_fetch_req", 32'(fetch_req), 32'h1);
    @(negedge clk);

    for (int h = 0; h < 256; h++) begin
      sv.instr   = {h[7:0], 8'($urandom_range(0, 255))};
      sv.flags   = 4'(h);
      sv.waitn   = 1;
      sv.exp_op  = ref_op(sv.instr);
      sv.exp_mem = ref_mem(sv.instr);
      run_instr(sv);
      n_chk++;
      if (!$onehot(op_out[22:0])) begin
        n_fail++;
        $display("FAIL sweep_onehot: got %0h expected one-hot", op_out[22:0]);
      end
    end

    instr_in = 16'h8105; flag_in = 4'h0; fetch_ack = 1'b1;
    @(negedge clk);
    fetch_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_mem_en", 32'(mem_en), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_phase", 32'(phase), 32'h1);
    chk("arst_op", 32'(op_out), 32'h1);
    chk("arst_mem_en", 32'(mem_en), 32'h0);
    chk("arst_count", 32'(instr_count), 32'h0);
    chk("arst_sat_count", 32'(s_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    run_instr(vt[2]);
    run_instr(vt[1]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
